// File: rtl/bram_responder.sv
// Block-RAM bus responder for the 0000_0000..0000_FFFF window; acks every strobe edge with a
// one-cycle ready pulse and masks the text-area I/O hole. Define BRAM_PARITY_EN for byte parity.
module bram_responder #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned RD_LAT    = 2,
    parameter logic [15:0] HOLE_BASE = 16'hFF00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cs,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_data,
`ifdef BRAM_PARITY_EN
    input  logic        i_inj_err,
    output logic        o_parity_err,
`endif
    output logic [31:0] o_data,
    output logic        o_data_ready,
    output logic        o_busy
);

    localparam int unsigned Depth = 2 ** ADDR_W;
`ifdef BRAM_PARITY_EN
    localparam int unsigned MemW = 36;
`else
    localparam int unsigned MemW = 32;
`endif

    typedef enum logic [1:0] {StIdle, StWrAck, StRdWait, StRdDone} state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                stb_q;
    logic [MemW-1:0]     mem [Depth];
    logic [MemW-1:0]     ram_q;
    logic [MemW-1:0]     rd_word;
    logic [MemW-1:0]     wr_word;
    logic [ADDR_W-1:0]   idx;
    logic                in_hole;
    logic                start;
    logic                unused_addr;

    assign idx         = i_addr[ADDR_W+1:2];
    assign in_hole     = (i_addr[15:7] == HOLE_BASE[15:7]);
    assign start       = i_stb & ~stb_q & i_cs & (state_q == StIdle);
    assign unused_addr = ^i_addr[1:0];

`ifdef BRAM_PARITY_EN
    function automatic logic [3:0] byte_par(input logic [31:0] d);
        logic [3:0] p;
        for (int b = 0; b < 4; b++) begin
            p[b] = ^d[8*b +: 8];
        end
        return p;
    endfunction

    assign wr_word = {byte_par(i_data) ^ {3'b000, i_inj_err}, i_data};
`else
    assign wr_word = i_data;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (i_we) begin
                        state_d = StWrAck;
                    end else if (RD_LAT <= 1) begin
                        state_d = StRdDone;
                    end else begin
                        state_d = StRdWait;
                        cnt_d   = 2'(RD_LAT - 2);
                    end
                end
            end
            StWrAck:  state_d = StIdle;
            StRdWait: begin
                if (cnt_q == '0) begin
                    state_d = StRdDone;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StRdDone: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            ram_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stb_q   <= i_stb;
            // RAM output register; hole reads load zero, which also zeroes the parity bits.
            if (start && !i_we) begin
                ram_q <= in_hole ? '0 : mem[idx];
            end
        end
    end

    // RAM array has no reset so contents survive a bus reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && start && i_we && !in_hole) begin
            mem[idx] <= wr_word;
        end
    end

    if (RD_LAT > 1) begin : g_out_reg
        logic [MemW-1:0] out_q;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                out_q <= '0;
            end else if (state_q == StRdWait && cnt_q == '0) begin
                out_q <= ram_q;
            end
        end

        assign rd_word = out_q;
    end else begin : g_no_out_reg
        // Single-cycle latency: the RAM output register loads at completion and holds.
        assign rd_word = ram_q;
    end

    assign o_data       = rd_word[31:0];
    assign o_data_ready = (state_q == StWrAck) || (state_q == StRdDone);
    assign o_busy       = (state_q != StIdle);

`ifdef BRAM_PARITY_EN
    assign o_parity_err = |(rd_word[35:32] ^ byte_par(rd_word[31:0]));
`endif

endmodule

// File: tb/tb_bram_responder.sv
// Directed plus randomized bench for bram_responder against an address-level RAM model.
module tb_bram_responder;

    localparam int RdLat = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cs;
    logic        i_stb;
    logic        i_we;
    logic [15:0] i_addr;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        o_data_ready;
    logic        o_busy;
`ifdef BRAM_PARITY_EN
    logic        i_inj_err;
    logic        o_parity_err;
`endif

    always #5 i_clk = ~i_clk;

    bram_responder #(
        .ADDR_W    (14),
        .RD_LAT    (RdLat),
        .HOLE_BASE (16'hFF00)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cs         (i_cs),
        .i_stb        (i_stb),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_data       (i_data),
`ifdef BRAM_PARITY_EN
        .i_inj_err    (i_inj_err),
        .o_parity_err (o_parity_err),
`endif
        .o_data       (o_data),
        .o_data_ready (o_data_ready),
        .o_busy       (o_busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          ready_cnt = 0;
    bit          prev_ready = 1'b0;
    bit          dbl_ready = 1'b0;
    bit          inj_mode = 1'b0;
    logic [31:0] model [int];
    bit          model_bad [int];
    logic [15:0] pool [10];

    always @(negedge i_clk) begin
        if (o_data_ready === 1'b1) begin
            ready_cnt++;
            if (prev_ready) dbl_ready = 1'b1;
        end
        prev_ready = (o_data_ready === 1'b1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_hole(input logic [15:0] a);
        return (a >= 16'hFF00) && (a < 16'hFF80);
    endfunction

    function automatic int word_of(input logic [15:0] a);
        return (int'(a) / 4) % 16384;
    endfunction

    function automatic logic [31:0] expect_rd(input logic [15:0] a);
        if (is_hole(a)) return 32'h0;
        if (model.exists(word_of(a))) return model[word_of(a)];
        return 32'h0;
    endfunction

    function automatic logic [31:0] expect_perr(input logic [15:0] a);
        if (is_hole(a)) return 32'h0;
        if (model_bad.exists(word_of(a))) return {31'h0, model_bad[word_of(a)]};
        return 32'h0;
    endfunction

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        i_cs   = 1'b1;
        i_stb  = 1'b1;
        i_we   = 1'b1;
        i_addr = a;
        i_data = d;
`ifdef BRAM_PARITY_EN
        i_inj_err = inj_mode;
`endif
        tick();
        check("wr_ready", {31'h0, o_data_ready}, 32'h1);
        check("wr_busy", {31'h0, o_busy}, 32'h1);
        i_stb = 1'b0;
        i_we  = 1'b0;
        tick();
        check("wr_ready_end", {31'h0, o_data_ready}, 32'h0);
        check("wr_busy_end", {31'h0, o_busy}, 32'h0);
        if (!is_hole(a)) begin
            model[word_of(a)]     = d;
            model_bad[word_of(a)] = inj_mode;
        end
    endtask

    task automatic rd(input logic [15:0] a);
        logic [31:0] exp;
        exp    = expect_rd(a);
        i_cs   = 1'b1;
        i_stb  = 1'b1;
        i_we   = 1'b0;
        i_addr = a;
        for (int k = 1; k <= RdLat; k++) begin
            tick();
            if (k == 1) i_stb = 1'b0;
            check("rd_busy", {31'h0, o_busy}, 32'h1);
            check("rd_ready", {31'h0, o_data_ready}, {31'h0, k == RdLat});
        end
        check("rd_data", o_data, exp);
`ifdef BRAM_PARITY_EN
        check("rd_perr", {31'h0, o_parity_err}, expect_perr(a));
`endif
        tick();
        check("rd_idle_busy", {31'h0, o_busy}, 32'h0);
        check("rd_idle_ready", {31'h0, o_data_ready}, 32'h0);
        check("rd_hold", o_data, exp);
    endtask

    initial begin
        int c0;
        i_rst  = 1'b1;
        i_cs   = 1'b0;
        i_stb  = 1'b0;
        i_we   = 1'b0;
        i_addr = '0;
        i_data = '0;
`ifdef BRAM_PARITY_EN
        i_inj_err = 1'b0;
`endif
        tick();
        tick();
        check("rst_data", o_data, 32'h0);
        check("rst_ready", {31'h0, o_data_ready}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        i_rst = 1'b0;
        tick();

        // RAM survives reset; output register does not
        wr(16'h0010, 32'hDEADBEEF);
        rd(16'h0010);
        i_rst = 1'b1;
        tick();
        check("rst2_data", o_data, 32'h0);
        check("rst2_ready", {31'h0, o_data_ready}, 32'h0);
        check("rst2_busy", {31'h0, o_busy}, 32'h0);
        i_rst = 1'b0;
        tick();
        rd(16'h0010);

        // byte-offset aliasing and the I/O hole
        wr(16'h0004, 32'h12345678);
        rd(16'h0006);
        wr(16'hFF04, 32'hFFFFFFFF);
        rd(16'hFF04);

        // strobe held high: one transaction only
        c0     = ready_cnt;
        i_cs   = 1'b1;
        i_we   = 1'b0;
        i_addr = 16'h0004;
        i_stb  = 1'b1;
        repeat (10) tick();
        i_stb = 1'b0;
        repeat (3) tick();
        check("held_pulses", ready_cnt - c0, 32'd1);
        check("held_data", o_data, 32'h12345678);

        // retrigger while busy is ignored, including a write
        c0     = ready_cnt;
        i_we   = 1'b0;
        i_addr = 16'h0010;
        i_stb  = 1'b1;
        tick();
        i_stb = 1'b0;
        tick();
        i_stb  = 1'b1;
        i_we   = 1'b1;
        i_data = 32'hBAD0BAD0;
        check("retrig_ready", {31'h0, o_data_ready}, 32'h1);
        check("retrig_data", o_data, 32'hDEADBEEF);
        tick();
        i_stb = 1'b0;
        i_we  = 1'b0;
        tick();
        tick();
        check("retrig_pulses", ready_cnt - c0, 32'd1);
        rd(16'h0010);

        // reset at edge+1 aborts the read
        i_addr = 16'h0004;
        i_stb  = 1'b1;
        tick();
        i_stb = 1'b0;
        i_rst = 1'b1;
        c0    = ready_cnt;
        tick();
        check("abort_ready", {31'h0, o_data_ready}, 32'h0);
        check("abort_busy", {31'h0, o_busy}, 32'h0);
        i_rst = 1'b0;
        tick();
        tick();
        check("abort_pulses", ready_cnt - c0, 32'd0);
        check("abort_data", o_data, 32'h0);

        // chip select dropped mid-read still completes
        i_addr = 16'h0006;
        i_stb  = 1'b1;
        tick();
        i_cs  = 1'b0;
        i_stb = 1'b0;
        check("csdrop_busy", {31'h0, o_busy}, 32'h1);
        tick();
        check("csdrop_ready", {31'h0, o_data_ready}, 32'h1);
        check("csdrop_data", o_data, 32'h12345678);
        tick();
        i_cs = 1'b1;

        // randomized traffic over a small address pool including hole words
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16'($urandom_range(0, 32'hFEFC)) & 16'hFFFC;
        end
        pool[8] = 16'hFF00;
        pool[9] = 16'hFF7C;
        for (int i = 0; i < 10; i++) begin
            wr(pool[i], $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = pool[$urandom_range(0, 9)] | 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) wr(a, $urandom);
            else rd(a);
        end

`ifdef BRAM_PARITY_EN
        inj_mode = 1'b1;
        wr(16'h0020, 32'hA5A50F0F);
        rd(16'h0020);
        inj_mode = 1'b0;
        wr(16'h0020, 32'hA5A50F0F);
        rd(16'h0020);
`endif

        check("no_double_ready", {31'h0, dbl_ready}, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
